// File: rtl/hazard_monitor.sv
// hazard_monitor: two-flop synchronizer, stability-window glitch filter and edge/glitch event counters.
// Define HAZ_MON_CNT_EN to build the saturating edge_cnt/glitch_cnt counters and their clr logic.
module hazard_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter logic        RST_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_in,
  input  logic             clr,
  output logic             f_filt,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic             glitch,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int unsigned     RUN_W    = 8;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES);
  localparam bit              ONE_SHOT = (STABLE_CYCLES == 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic [RUN_W-1:0] run_cnt;
  logic             differ_c;
  logic             commit_c;
  logic             reject_c;

  // Two-flop synchronizer; only s2 feeds the filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_LEVEL;
      s2 <= RST_LEVEL;
    end else begin
      s1 <= f_in;
      s2 <= s1;
    end
  end

  // Commit/reject decision for the current edge, shared by the FSM and the counters.
  always_comb begin
    differ_c = (s2 != f_filt);
    commit_c = 1'b0;
    reject_c = 1'b0;
    case (state)
      ST_STABLE: begin
        commit_c = differ_c && ONE_SHOT;
      end
      ST_PENDING: begin
        commit_c = differ_c && ((run_cnt + RUN_W'(1)) == RUN_LAST);
        reject_c = !differ_c;
      end
      default: begin
        commit_c = 1'b0;
        reject_c = 1'b0;
      end
    endcase
  end

  // Filter FSM with registered level and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_STABLE;
      run_cnt   <= '0;
      f_filt    <= RST_LEVEL;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
      glitch    <= 1'b0;
    end else begin
      edge_rise <= commit_c && !f_filt;
      edge_fall <= commit_c && f_filt;
      glitch    <= reject_c;
      if (commit_c) begin
        f_filt <= ~f_filt;
      end
      case (state)
        ST_STABLE: begin
          if (differ_c) begin
            run_cnt <= RUN_W'(1);
            state   <= commit_c ? ST_STABLE : ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (commit_c || reject_c) begin
            run_cnt <= '0;
            state   <= ST_STABLE;
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
        end
        default: begin
          run_cnt <= '0;
          state   <= ST_STABLE;
        end
      endcase
    end
  end

`ifdef HAZ_MON_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating event counters; clr beats a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt   <= '0;
      glitch_cnt <= '0;
    end else if (clr) begin
      edge_cnt   <= '0;
      glitch_cnt <= '0;
    end else begin
      if (commit_c && (edge_cnt != CNT_MAX)) begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
      if (reject_c && (glitch_cnt != CNT_MAX)) begin
        glitch_cnt <= glitch_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_clr;

  assign edge_cnt   = '0;
  assign glitch_cnt = '0;
  assign unused_clr = clr;
`endif

endmodule

// File: tb/tb_hazard_monitor.sv
// Bench for hazard_monitor: random and directed f_in traffic checked every cycle against a
// sample-window reference model (a level commits once the last STABLE_CYCLES filter samples all differ).
module tb_hazard_monitor;

  localparam int unsigned SC     = 4;
  localparam int unsigned CW     = 8;
  localparam logic        RL     = 1'b0;
  localparam int          CNTMAX = (1 << CW) - 1;
`ifdef HAZ_MON_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          f_in = 1'b0;
  logic          clr = 1'b0;
  logic          f_filt;
  logic          edge_rise;
  logic          edge_fall;
  logic          glitch;
  logic [CW-1:0] edge_cnt;
  logic [CW-1:0] glitch_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic m_dly[$];
  logic m_win[$];
  logic m_filt, m_prev, m_rise, m_fall, m_gl;
  int   m_ecnt, m_gcnt;

  hazard_monitor #(
    .STABLE_CYCLES(SC),
    .CNT_W        (CW),
    .RST_LEVEL    (RL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_in      (f_in),
    .clr       (clr),
    .f_filt    (f_filt),
    .edge_rise (edge_rise),
    .edge_fall (edge_fall),
    .glitch    (glitch),
    .edge_cnt  (edge_cnt),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cnt_exp(input int v);
    return CNT_EN ? v : 0;
  endfunction

  task automatic model_reset();
    m_dly = '{RL, RL};
    m_win.delete();
    m_filt = RL;
    m_prev = RL;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_gl   = 1'b0;
    m_ecnt = 0;
    m_gcnt = 0;
  endtask

  // One clock edge: the filter sees f_in from two edges ago.
  task automatic model_edge(input logic fin, input logic c);
    logic seen, all_diff, dummy;
    seen = m_dly.pop_front();
    m_dly.push_back(fin);
    m_win.push_back(seen);
    if (m_win.size() > SC) dummy = m_win.pop_front();
    all_diff = (m_win.size() == SC);
    foreach (m_win[i]) if (m_win[i] == m_filt) all_diff = 1'b0;
    m_gl   = (seen == m_filt) && (m_prev != m_filt);
    m_rise = all_diff && !m_filt;
    m_fall = all_diff && m_filt;
    if (all_diff) m_filt = ~m_filt;
    m_prev = seen;
    if (c) begin
      m_ecnt = 0;
      m_gcnt = 0;
    end else begin
      if (all_diff && m_ecnt < CNTMAX) m_ecnt++;
      if (m_gl && m_gcnt < CNTMAX) m_gcnt++;
    end
  endtask

  task automatic compare_all();
    check("f_filt", 32'(f_filt), 32'(m_filt));
    check("edge_rise", 32'(edge_rise), 32'(m_rise));
    check("edge_fall", 32'(edge_fall), 32'(m_fall));
    check("glitch", 32'(glitch), 32'(m_gl));
    check("edge_cnt", 32'(edge_cnt), 32'(cnt_exp(m_ecnt)));
    check("glitch_cnt", 32'(glitch_cnt), 32'(cnt_exp(m_gcnt)));
  endtask

  // Drive inputs just after an edge, clock once, then check against the model.
  task automatic cyc(input logic fin, input logic c);
    f_in = fin;
    clr  = c;
    @(posedge clk);
    model_edge(fin, c);
    #1;
    compare_all();
  endtask

  task automatic apply_reset(input logic fin, input int cycles);
    #2;
    rst_n = 1'b0;
    f_in  = fin;
    clr   = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_rise, n_fall, n_gl, idx, len, n;
    logic lvl;

    model_reset();
    #1;

    // Reset held with f_in high, then quiet after release
    apply_reset(1'b1, 3);
    check("rst_f_filt", 32'(f_filt), 32'(RL));
    check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0);
      n += int'(edge_rise) + int'(edge_fall) + int'(glitch);
    end
    check("quiet_events", 32'(n), 32'd0);

    // Clean rise
    n_rise = 0;
    idx = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      n_rise += int'(edge_rise);
      if (f_filt && idx < 0) idx = i;
    end
    check("rise_edge_idx", 32'(idx), 32'(SC + 1));
    check("rise_pulses", 32'(n_rise), 32'd1);
    check("rise_edge_cnt", 32'(edge_cnt), 32'(cnt_exp(1)));
    check("rise_glitch_cnt", 32'(glitch_cnt), 32'd0);

    // Back to 0, then a two-cycle glitch
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    n_gl = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(i < 2, 1'b0);
      n_gl += int'(glitch);
      n += int'(edge_rise) + int'(edge_fall) + int'(f_filt);
    end
    check("glitch_pulses", 32'(n_gl), 32'd1);
    check("glitch_cnt_one", 32'(glitch_cnt), 32'(cnt_exp(1)));
    check("glitch_no_edge", 32'(n), 32'd0);

    // Saturation of the glitch counter, then clr
    for (int g = 0; g < 256; g++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (4) cyc(1'b0, 1'b0);
    end
    check("sat_glitch_cnt", 32'(glitch_cnt), 32'(cnt_exp(CNTMAX)));
    n_gl = 0;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 6; i++) begin
        cyc(i < 2, 1'b0);
        n_gl += int'(glitch);
      end
    end
    check("sat_more_pulses", 32'(n_gl), 32'd3);
    check("sat_hold", 32'(glitch_cnt), 32'(cnt_exp(CNTMAX)));
    cyc(1'b0, 1'b1);
    check("clr_glitch_cnt", 32'(glitch_cnt), 32'd0);

    // Mid-PENDING asynchronous reset: no glitch for the aborted transition
    repeat (4) cyc(1'b1, 1'b0);
    apply_reset(1'b0, 2);
    check("midrst_f_filt", 32'(f_filt), 32'(RL));
    n_gl = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0);
      n_gl += int'(glitch);
    end
    check("midrst_no_glitch", 32'(n_gl), 32'd0);

    // Random levels with random hold lengths and occasional clr
    for (int seg = 0; seg < 150; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) cyc(lvl, ($urandom_range(0, 39) == 0));
    end

    // clr on the commit edge of a fall
    repeat (10) cyc(1'b1, 1'b0);
    check("pre_fall_f_filt", 32'(f_filt), 32'd1);
    repeat (SC + 1) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("clr_commit_fall", 32'(edge_fall), 32'd1);
    check("clr_commit_cnt", 32'(edge_cnt), 32'd0);
    check("clr_commit_filt", 32'(f_filt), 32'd0);
    n_fall = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      n_fall += int'(edge_fall);
    end
    check("fall_single_pulse", 32'(n_fall), 32'd0);

    // Netlist stand-in: F rises mid-cycle, well away from the clock edge
    apply_reset(1'b0, 2);
    repeat (3) cyc(1'b0, 1'b0);
    #4;
    f_in = 1'b1;
    n = 21;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (f_filt) begin
        n = i;
        break;
      end
    end
    check("netlist_latency_edges", 32'(n), 32'(SC + 2));
    check("netlist_rise_pulse", 32'(edge_rise), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
